// File: rtl/reg_file_sb.sv
// Register file with two write ports, write-to-read bypass and a load-pending scoreboard.
// Register 0 is hardwired to zero; hazard stalls reads of registers awaiting a load.
module reg_file_sb #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    rs,
    input  logic [ADDR_W-1:0]    rt,
    input  logic                 re,
    output logic [DATA_W-1:0]    dataOutA,
    output logic [DATA_W-1:0]    dataOutB,
    input  logic                 wa_en,
    input  logic [ADDR_W-1:0]    wa_addr,
    input  logic [DATA_W-1:0]    wa_data,
    input  logic                 wb_en,
    input  logic [ADDR_W-1:0]    wb_addr,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 pend_set,
    input  logic [ADDR_W-1:0]    pend_addr,
    output logic                 hazard,
    output logic [2**ADDR_W-1:0] pending
);

    localparam int NReg = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NReg];
    logic [NReg-1:0]   pend_q, pend_d;
    logic [DATA_W-1:0] out_a_q, out_b_q;
    logic [DATA_W-1:0] byp_a, byp_b;
    logic              hit_a, hit_b;

    // A load returning this cycle resolves its own hazard through the bypass path.
    always_comb begin
        hit_a  = (rs != '0) && pend_q[rs] && !(wb_en && (wb_addr == rs));
        hit_b  = (rt != '0) && pend_q[rt] && !(wb_en && (wb_addr == rt));
        hazard = re && (hit_a || hit_b);
    end

    always_comb begin
        byp_a = regs_q[rs];
        if (rs == '0) begin
            byp_a = '0;
        end else if (wa_en && (wa_addr == rs)) begin
            byp_a = wa_data;
        end else if (wb_en && (wb_addr == rs)) begin
            byp_a = wb_data;
        end
    end

    always_comb begin
        byp_b = regs_q[rt];
        if (rt == '0) begin
            byp_b = '0;
        end else if (wa_en && (wa_addr == rt)) begin
            byp_b = wa_data;
        end else if (wb_en && (wb_addr == rt)) begin
            byp_b = wb_data;
        end
    end

    // Set beats clear so a freshly issued load is not lost to an older one returning.
    always_comb begin
        pend_d = pend_q;
        if (wb_en) begin
            pend_d[wb_addr] = 1'b0;
        end
        if (pend_set) begin
            pend_d[pend_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NReg; i++) begin
                regs_q[i] <= '0;
            end
            pend_q  <= '0;
            out_a_q <= '0;
            out_b_q <= '0;
        end else begin
            regs_q[0] <= '0;
            // Port A is the younger instruction and wins an address collision.
            for (int i = 1; i < NReg; i++) begin
                if (wa_en && (wa_addr == ADDR_W'(i))) begin
                    regs_q[i] <= wa_data;
                end else if (wb_en && (wb_addr == ADDR_W'(i))) begin
                    regs_q[i] <= wb_data;
                end
            end
            pend_q <= pend_d;
            if (re && !hazard) begin
                out_a_q <= byp_a;
                out_b_q <= byp_b;
            end
        end
    end

    assign dataOutA = out_a_q;
    assign dataOutB = out_b_q;
    assign pending  = pend_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: bypass, register 0, scoreboard hazards, conflicts, reset.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  rs, rt, wa_addr, wb_addr, pend_addr;
    logic        re, wa_en, wb_en, pend_set;
    logic [23:0] wa_data, wb_data;
    logic [23:0] dataOutA, dataOutB;
    logic        hazard;
    logic [7:0]  pending;

    int n_checks = 0;
    int n_errors = 0;

    reg_file_sb #(
        .DATA_W(24),
        .ADDR_W(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs       (rs),
        .rt       (rt),
        .re       (re),
        .dataOutA (dataOutA),
        .dataOutB (dataOutB),
        .wa_en    (wa_en),
        .wa_addr  (wa_addr),
        .wa_data  (wa_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .pend_set (pend_set),
        .pend_addr(pend_addr),
        .hazard   (hazard),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; re = 1'b0; rs = '0; rt = '0;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        pend_set = 1'b0; pend_addr = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_a", dataOutA, 0);
        check("rst_b", dataOutB, 0);
        check("rst_pending", pending, 0);

        // Plain read after reset
        re = 1'b1; rs = 3'd3; rt = 3'd5;
        #1 check("rst_hazard", hazard, 0);
        tick();
        check("read35_a", dataOutA, 0);
        check("read35_b", dataOutB, 0);

        // Write port A bypassed into same-cycle read
        wa_en = 1'b1; wa_addr = 3'd2; wa_data = 24'hC0FFEE; rs = 3'd2; rt = 3'd3;
        tick();
        check("bypass_a", dataOutA, 24'hC0FFEE);
        check("bypass_b_other", dataOutB, 0);
        wa_en = 1'b0; rs = 3'd2; rt = 3'd2;
        tick();
        check("stored_a", dataOutA, 24'hC0FFEE);
        check("stored_b", dataOutB, 24'hC0FFEE);

        // Register 0 ignores writes and pend_set
        re = 1'b0; wa_en = 1'b1; wa_addr = 3'd0; wa_data = 24'hDEADBE;
        tick();
        wa_en = 1'b0; re = 1'b1; rs = 3'd0; rt = 3'd2;
        tick();
        check("r0_read", dataOutA, 0);
        check("r0_read_b", dataOutB, 24'hC0FFEE);
        re = 1'b0; pend_set = 1'b1; pend_addr = 3'd0;
        tick();
        pend_set = 1'b0;
        check("r0_pend", pending, 0);

        // Load pending on r4: hazard stalls and holds outputs
        re = 1'b1; rs = 3'd2; rt = 3'd0;
        wa_en = 1'b1; wa_addr = 3'd4; wa_data = 24'h123456;
        pend_set = 1'b1; pend_addr = 3'd4;
        tick();
        wa_en = 1'b0; pend_set = 1'b0;
        check("pre_stall_a", dataOutA, 24'hC0FFEE);
        check("pend4_set", pending, 8'h10);
        rs = 3'd4; rt = 3'd0;
        #1 check("hazard_r4", hazard, 1);
        re = 1'b0;
        #1 check("hazard_no_re", hazard, 0);
        re = 1'b1;
        tick();
        check("stall_hold_a", dataOutA, 24'hC0FFEE);
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 24'hFEEDBA;
        #1 check("hazard_resolved", hazard, 0);
        tick();
        wb_en = 1'b0;
        check("load_bypass_a", dataOutA, 24'hFEEDBA);
        check("pend4_clear", pending, 0);

        // Same-address write conflict: port A wins
        re = 1'b0;
        wa_en = 1'b1; wa_addr = 3'd6; wa_data = 24'h111111;
        wb_en = 1'b1; wb_addr = 3'd6; wb_data = 24'h222222;
        tick();
        wa_en = 1'b0; wb_en = 1'b0; re = 1'b1; rs = 3'd6; rt = 3'd4;
        tick();
        check("conflict_store", dataOutA, 24'h111111);
        check("r4_stored", dataOutB, 24'hFEEDBA);

        // Bypass priority with both ports on r5
        wa_en = 1'b1; wa_addr = 3'd5; wa_data = 24'hAAAAAA;
        wb_en = 1'b1; wb_addr = 3'd5; wb_data = 24'hBBBBBB;
        rs = 3'd5; rt = 3'd5;
        tick();
        wa_en = 1'b0; wb_en = 1'b0;
        check("conflict_bypass", dataOutA, 24'hAAAAAA);

        // Set and clear on r7 together: set wins
        re = 1'b0;
        pend_set = 1'b1; pend_addr = 3'd7;
        wb_en = 1'b1; wb_addr = 3'd7; wb_data = 24'h333333;
        tick();
        pend_set = 1'b0; wb_en = 1'b0;
        check("set_wins", pending, 8'h80);
        re = 1'b1; rs = 3'd0; rt = 3'd7;
        #1 check("hazard_rt", hazard, 1);
        re = 1'b0;

        // Reset mid-stall clears scoreboard, registers and outputs
        pend_set = 1'b1; pend_addr = 3'd1;
        tick();
        pend_set = 1'b0;
        check("pend1_set", pending, 8'h82);
        re = 1'b1; rs = 3'd1; rt = 3'd0;
        #1 check("hazard_r1", hazard, 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_pending", pending, 0);
        check("mid_rst_hazard", hazard, 0);
        check("mid_rst_a", dataOutA, 0);
        check("mid_rst_b", dataOutB, 0);
        rst_n = 1'b1; re = 1'b1; rs = 3'd1; rt = 3'd7;
        tick();
        check("post_rst_r1", dataOutA, 0);
        check("post_rst_r7", dataOutB, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor of the 8x24 register file for the MIPS-24 core.
- Two synchronous read ports and two write ports:
  - port A: ALU writeback.
  - port B: load/memory writeback.
- Write-to-read bypass so reads in the same cycle as a write see the new value.
- Per-register pending scoreboard for outstanding loads, with a combinational hazard output the controller uses to stall decode.

Parameters:
DATA_W, 24, register width in bits
ADDR_W, 3, register index width; register count is 2**ADDR_W

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
rs  in  ADDR_W  read port A index
rt  in  ADDR_W  read port B index
re  in  1  read enable
dataOutA  out  DATA_W  registered read data for rs
dataOutB  out  DATA_W  registered read data for rt
wa_en  in  1  write port A enable (ALU)
wa_addr  in  ADDR_W  write port A index
wa_data  in  DATA_W  write port A data
wb_en  in  1  write port B enable (load return)
wb_addr  in  ADDR_W  write port B index
wb_data  in  DATA_W  write port B data
pend_set  in  1  mark pend_addr as awaiting a load
pend_addr  in  ADDR_W  register to mark pending
hazard  out  1  combinational: current read must stall
pending  out  2**ADDR_W  scoreboard bits, bit i = register i pending

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low. On a rising edge with rst_n=0:
  - all registers = 0;
  - pending = 0;
  - dataOutA = dataOutB = 0.
  - While rst_n=0, all writes, pend_set and reads are ignored.
- Register 0:
  - Hardwired zero. Writes to index 0 are dropped and pend_set to index 0 is dropped.
  - Reads of index 0 return 0 and never raise hazard.
- Writes:
  - Committed on the rising edge.
  - wa_en and wb_en both set with equal nonzero addresses: port A data is stored (younger instruction wins). The pending bit is still cleared by port B.
  - Different addresses: both are written.
- Scoreboard, per rising edge:
  - wb_en=1 clears pending[wb_addr].
  - pend_set=1 sets pending[pend_addr].
  - Same index set and cleared in the same cycle: set wins (a new load was issued).
  - wa_en does not touch pending.
- hazard is combinational:
  - hazard = re AND (hitA OR hitB).
  - hitA = rs!=0 AND pending[rs] AND NOT(wb_en AND wb_addr==rs). hitB is the same with rt.
  - A load returning in the same cycle resolves the hazard via bypass.
- Read:
  - Latency is 1 cycle.
  - On a rising edge with re=1 and hazard=0, each output loads its bypassed value in this priority order:
    1. index 0 gives 0;
    2. wa_en and wa_addr==index gives wa_data;
    3. wb_en and wb_addr==index gives wb_data;
    4. otherwise the stored register.
  - re=0, or re=1 with hazard=1: dataOutA and dataOutB hold their previous values.
  - Reads and writes are independent. A write in the same cycle as re=1 is performed and also bypassed. There is no read/write mutual exclusion.
- Width rules:
  - Data is stored and forwarded unmodified at DATA_W.
  - Indices are ADDR_W bits, so there is no out-of-range case.
- Reset mid-operation:
  - Pending loads are forgotten (pending=0).
  - A wb_en arriving after reset still writes normally; it is the controller's job to squash it.

Test Plan:
- Reset, then re=1, rs=3, rt=5 -> dataOutA=0, dataOutB=0, hazard=0, pending=0.
- wa_en=1, wa_addr=2, wa_data=24'hC0FFEE in the same cycle as re=1, rs=2 -> next cycle dataOutA=C0FFEE (bypass). A later read of rs=2 with no write also gives C0FFEE.
- wa_en=1, wa_addr=0, wa_data=24'hDEADBE, then read rs=0 -> dataOutA=0. pend_set with pend_addr=0 -> pending[0] stays 0.
- pend_set=1, pend_addr=4, then re=1, rs=4:
  - hazard=1 and dataOutA holds its prior value.
  - Next cycle wb_en=1, wb_addr=4, wb_data=24'hFEEDBA -> hazard=0 that cycle, then dataOutA=FEEDBA and pending[4]=0.
- Same-cycle conflicts:
  - wa_en and wb_en both targeting index 6 with data 24'h111111 and 24'h222222 -> register 6 reads back 111111.
  - pend_set=1 and wb_en=1 both on index 7 -> pending[7]=1 afterwards.
- pend_set on index 1, rst_n=0 for one cycle mid-stall -> pending=0, hazard=0, outputs 0. After reset, a read of 1 gives 0.
